// File: rtl/rtsnoc_ping_sm_if.sv
// rtl/rtsnoc_ping_sm_if.sv - router local-port bundle between the ping node and its RTSNoC router
// Packets are carried on a fixed 38-bit bus; the node uses the low NOC_BUS_SIZE bits.
interface rtsnoc_ping_sm_if;
  logic [37:0] din_o;
  logic        wr_o;
  logic        rd_o;
  logic [37:0] dout_i;
  logic        wait_i;
  logic        nd_i;

  modport master (
    output din_o,
    output wr_o,
    output rd_o,
    input  dout_i,
    input  wait_i,
    input  nd_i
  );

  modport slave (
    input  din_o,
    input  wr_o,
    input  rd_o,
    output dout_i,
    output wait_i,
    output nd_i
  );
endinterface

// File: rtl/rtsnoc_ping_sm.sv
// rtl/rtsnoc_ping_sm.sv - RTSNoC echo-protocol initiator (built-in self-test ping node)
// Optional round-trip latency tracking is enabled with RTSNOC_PING_LATENCY_EN.
module rtsnoc_ping_sm #(
  parameter int SOC_SIZE_X     = 1,
  parameter int SOC_SIZE_Y     = 1,
  parameter int NOC_DATA_WIDTH = 16,
  parameter int MY_X           = 0,
  parameter int MY_Y           = 0,
  parameter int MY_LOCAL       = 0,
  parameter int DATA_SEED      = 0,
  parameter int TIMEOUT        = 1023
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  start_i,
  input  logic [15:0]           count_i,
  input  logic [SOC_SIZE_X-1:0] dst_x_i,
  input  logic [SOC_SIZE_Y-1:0] dst_y_i,
  input  logic [2:0]            dst_local_i,
  rtsnoc_ping_sm_if.master      rtr,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  pass_o,
  output logic [15:0]           err_cnt_o,
  output logic [15:0]           rx_cnt_o,
  output logic [15:0]           lat_max_o
);

  localparam int NOC_HEADER_SIZE = 2*SOC_SIZE_X + 2*SOC_SIZE_Y + 6;
  localparam int NOC_BUS_SIZE    = NOC_DATA_WIDTH + NOC_HEADER_SIZE;
  localparam int ADDR_W          = SOC_SIZE_X + SOC_SIZE_Y + 3;

  localparam logic [ADDR_W-1:0]         L_ME       = {SOC_SIZE_X'(MY_X), SOC_SIZE_Y'(MY_Y), 3'(MY_LOCAL)};
  localparam logic [NOC_DATA_WIDTH-1:0] L_SEED     = NOC_DATA_WIDTH'(DATA_SEED);
  localparam logic [15:0]               L_TO_LAST  = 16'(TIMEOUT - 1);
  // Bits of the 38-bit bus above the packet; a reply with any of them set is malformed.
  localparam logic [37:0]               L_PAD_MASK = ~((38'd1 << NOC_BUS_SIZE) - 38'd1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_RXWAIT,
    S_CHECK,
    S_NEXT,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [NOC_DATA_WIDTH-1:0] r_seq;
  logic [15:0]               r_remain;
  logic [ADDR_W-1:0]         r_dst;
  logic [NOC_BUS_SIZE-1:0]   r_din;
  logic [37:0]               r_rx;
  logic [15:0]               r_timer;
  logic [15:0]               r_err;
  logic [15:0]               r_rx_cnt;
  logic                      r_busy;
  logic                      r_done;
  logic                      r_pass;

  logic                      w_wr;
  logic                      w_rd;
  logic                      w_start;
  logic                      w_expire;
  logic                      w_last;
  logic                      w_mismatch;
  logic [NOC_DATA_WIDTH-1:0] w_seq_inc;
  logic [ADDR_W-1:0]         w_dst_in;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign w_seq_inc = r_seq + NOC_DATA_WIDTH'(1);
  assign w_dst_in  = {dst_x_i, dst_y_i, dst_local_i};

  // The echo node swaps the address halves, so its orig must be our target and its dst must be us.
  assign w_mismatch = (r_rx[NOC_DATA_WIDTH-1:0] != r_seq)
                   || (r_rx[NOC_BUS_SIZE-1 -: ADDR_W] != r_dst)
                   || (r_rx[NOC_DATA_WIDTH +: ADDR_W] != L_ME)
                   || ((r_rx & L_PAD_MASK) != 38'd0);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next   = r_state;
    w_wr     = 1'b0;
    w_rd     = 1'b0;
    w_start  = 1'b0;
    w_expire = 1'b0;
    w_last   = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          w_start = 1'b1;
          w_next  = (count_i == 16'd0) ? S_DONE : S_SEND;
        end
      end
      S_SEND: begin
        if (!rtr.wait_i) begin
          w_wr   = 1'b1;
          w_next = S_RXWAIT;
        end
      end
      S_RXWAIT: begin
        // A reply landing on the expiry cycle still counts as a reply.
        if (rtr.nd_i) begin
          w_rd   = 1'b1;
          w_next = S_CHECK;
        end else if (r_timer == L_TO_LAST) begin
          w_expire = 1'b1;
          w_next   = S_NEXT;
        end
      end
      S_CHECK: begin
        w_next = S_NEXT;
      end
      S_NEXT: begin
        w_last = (r_remain <= 16'd1);
        w_next = w_last ? S_DONE : S_SEND;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_seq    <= L_SEED;
      r_remain <= 16'd0;
      r_dst    <= '0;
      r_din    <= '0;
      r_rx     <= '0;
      r_timer  <= 16'd0;
      r_err    <= 16'd0;
      r_rx_cnt <= 16'd0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_pass   <= 1'b0;
    end else begin
      if (w_start) begin
        r_remain <= count_i;
        r_dst    <= w_dst_in;
        r_seq    <= L_SEED;
        r_din    <= {L_ME, w_dst_in, L_SEED};
        r_err    <= 16'd0;
        r_rx_cnt <= 16'd0;
        r_busy   <= (count_i != 16'd0);
        r_done   <= (count_i == 16'd0);
        r_pass   <= (count_i == 16'd0);
      end

      if (w_wr) begin
        r_timer <= 16'd0;
      end else if (r_state == S_RXWAIT) begin
        r_timer <= r_timer + 16'd1;
      end

      if (w_rd) begin
        r_rx <= rtr.dout_i;
      end

      if (w_expire) begin
        r_err <= sat_inc(r_err);
      end

      if (r_state == S_CHECK) begin
        r_rx_cnt <= sat_inc(r_rx_cnt);
        if (w_mismatch) begin
          r_err <= sat_inc(r_err);
        end
      end

      if (r_state == S_NEXT) begin
        r_remain <= r_remain - 16'd1;
        r_seq    <= w_seq_inc;
        if (w_last) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
          r_pass <= (r_err == 16'd0);
        end else begin
          r_din <= {L_ME, r_dst, w_seq_inc};
        end
      end
    end
  end

`ifdef RTSNOC_PING_LATENCY_EN
  logic [15:0] r_lat;
  logic [15:0] r_lat_max;
  logic [15:0] w_lat_now;

  // Latency counts the cycles after the write up to and including the nd_i cycle.
  assign w_lat_now = sat_inc(r_lat);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_lat     <= 16'd0;
      r_lat_max <= 16'd0;
    end else begin
      if (w_start) begin
        r_lat_max <= 16'd0;
      end
      if (w_wr) begin
        r_lat <= 16'd0;
      end else if (r_state == S_RXWAIT) begin
        r_lat <= w_lat_now;
      end
      if (w_rd && (w_lat_now > r_lat_max)) begin
        r_lat_max <= w_lat_now;
      end
    end
  end

  assign lat_max_o = r_lat_max;
`else
  assign lat_max_o = 16'd0;
`endif

  assign rtr.din_o = 38'(r_din);
  assign rtr.wr_o  = w_wr;
  assign rtr.rd_o  = w_rd;

  assign busy_o    = r_busy;
  assign done_o    = r_done;
  assign pass_o    = r_pass;
  assign err_cnt_o = r_err;
  assign rx_cnt_o  = r_rx_cnt;

endmodule

// File: tb/tb_rtsnoc_ping_sm.sv
// tb/tb_rtsnoc_ping_sm.sv - scoreboard bench for rtsnoc_ping_sm with a behavioural echo node
module tb_rtsnoc_ping_sm;

  typedef struct {
    logic        pass;
    logic [15:0] err;
    logic [15:0] rx;
    logic [15:0] lat;
  } res_t;

`ifdef RTSNOC_PING_LATENCY_EN
  localparam logic [15:0] ECHO_LAT = 16'd3;
`else
  localparam logic [15:0] ECHO_LAT = 16'd0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] count;
  logic        dst_x;
  logic        dst_y;
  logic [2:0]  dst_local;
  logic        busy;
  logic        done;
  logic        pass;
  logic [15:0] err_cnt;
  logic [15:0] rx_cnt;
  logic [15:0] lat_max;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [37:0] exp_pkt_q[$];
  res_t        exp_res_q[$];
  bit          echo_on = 1'b0;
  int          corrupt_idx = -1;
  int          pkt_idx = 0;
  logic        done_q = 1'b0;

  always #5 clk = ~clk;

  rtsnoc_ping_sm_if rtr ();

  rtsnoc_ping_sm #(
    .SOC_SIZE_X     (1),
    .SOC_SIZE_Y     (1),
    .NOC_DATA_WIDTH (16),
    .MY_X           (0),
    .MY_Y           (0),
    .MY_LOCAL       (0),
    .DATA_SEED      (0),
    .TIMEOUT        (15)
  ) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .start_i     (start),
    .count_i     (count),
    .dst_x_i     (dst_x),
    .dst_y_i     (dst_y),
    .dst_local_i (dst_local),
    .rtr         (rtr),
    .busy_o      (busy),
    .done_o      (done),
    .pass_o      (pass),
    .err_cnt_o   (err_cnt),
    .rx_cnt_o    (rx_cnt),
    .lat_max_o   (lat_max)
  );

  task automatic chk(input string name, input logic [37:0] act, input logic [37:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  // Outgoing packet: orig=(0,0,0) in [25:21], dst=(1,1,2) in [20:16], payload in [15:0].
  function automatic logic [37:0] tx_pkt(input int seq);
    logic [37:0] p;
    p        = 38'd0;
    p[15:0]  = 16'(seq);
    p[18:16] = 3'd2;
    p[19]    = 1'b1;
    p[20]    = 1'b1;
    return p;
  endfunction

  // Echo reply: orig=(1,1,2) in [25:21], dst=(0,0,0) in [20:16].
  function automatic logic [37:0] rx_pkt(input logic [15:0] data);
    logic [37:0] p;
    p        = 38'd0;
    p[15:0]  = data;
    p[23:21] = 3'd2;
    p[24]    = 1'b1;
    p[25]    = 1'b1;
    return p;
  endfunction

  always @(negedge clk) begin
    if (rtr.wr_o === 1'b1) begin
      if (exp_pkt_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_wr: got din 0x%0h expected no write", rtr.din_o);
      end else begin
        chk("din_o", rtr.din_o, exp_pkt_q.pop_front());
      end
      chk("rd_with_wr", 38'(rtr.rd_o), 38'd0);
    end
    if (rtr.rd_o === 1'b1 && !echo_on) begin
      chk("rd_without_reply", 38'(rtr.rd_o), 38'd0);
    end
    if (done === 1'b1 && done_q !== 1'b1) begin
      if (exp_res_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: got done=1 expected no completion");
      end else begin
        res_t r;
        r = exp_res_q.pop_front();
        chk("pass_o", 38'(pass), 38'(r.pass));
        chk("err_cnt_o", 38'(err_cnt), 38'(r.err));
        chk("rx_cnt_o", 38'(rx_cnt), 38'(r.rx));
        chk("lat_max_o", 38'(lat_max), 38'(r.lat));
        chk("busy_at_done", 38'(busy), 38'd0);
      end
    end
    done_q <= done;
  end

  initial begin
    logic [37:0] reply;
    bool_loop: begin end
    rtr.nd_i   = 1'b0;
    rtr.dout_i = 38'd0;
    forever begin
      @(negedge clk);
      if (rtr.wr_o === 1'b1 && echo_on) begin
        bit got_rd;
        reply = rx_pkt((pkt_idx == corrupt_idx) ? 16'h00FF : rtr.din_o[15:0]);
        repeat (3) @(posedge clk);
        #1;
        rtr.dout_i = reply;
        rtr.nd_i   = 1'b1;
        got_rd     = 1'b0;
        for (int i = 0; i < 50; i++) begin
          @(negedge clk);
          if (rtr.rd_o === 1'b1) begin
            got_rd = 1'b1;
            break;
          end
        end
        if (!got_rd) begin
          n_cmp++;
          n_bad++;
          $display("FAIL echo_rd_timeout: got no rd_o expected rd_o within 50 cycles");
        end
        @(posedge clk);
        #1;
        rtr.nd_i = 1'b0;
        pkt_idx++;
      end
    end
  end

  task automatic pulse_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic run(input int cnt, input bit echo, input int corrupt, input int wait_cyc,
                     input res_t r, output int cycles);
    pkt_idx     = 0;
    echo_on     = echo;
    corrupt_idx = corrupt;
    for (int i = 0; i < cnt; i++) exp_pkt_q.push_back(tx_pkt(i));
    exp_res_q.push_back(r);
    count      = 16'(cnt);
    rtr.wait_i = (wait_cyc > 0);
    pulse_start();
    if (wait_cyc > 0) begin
      for (int i = 0; i < wait_cyc; i++) begin
        @(negedge clk);
        chk("wr_held_by_wait", 38'(rtr.wr_o), 38'd0);
        chk("din_stable_in_wait", rtr.din_o, tx_pkt(0));
      end
      @(posedge clk);
      #1 rtr.wait_i = 1'b0;
    end
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (done !== 1'b1 && cycles < 2000);
    if (done !== 1'b1) begin
      n_cmp++;
      n_bad++;
      $display("FAIL done_timeout: got done=%0b expected 1 within 2000 cycles", done);
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, 38'(busy), 38'd0);
    chk({tag, "_done"}, 38'(done), 38'd0);
    chk({tag, "_pass"}, 38'(pass), 38'd0);
    chk({tag, "_err"}, 38'(err_cnt), 38'd0);
    chk({tag, "_rx"}, 38'(rx_cnt), 38'd0);
    chk({tag, "_lat"}, 38'(lat_max), 38'd0);
    chk({tag, "_wr"}, 38'(rtr.wr_o), 38'd0);
    chk({tag, "_rd"}, 38'(rtr.rd_o), 38'd0);
    chk({tag, "_din"}, rtr.din_o, 38'd0);
  endtask

  initial begin
    res_t r;
    int   cyc;
    bit   saw_wr;
    rst_n      = 1'b0;
    start      = 1'b0;
    count      = 16'd0;
    dst_x      = 1'b1;
    dst_y      = 1'b1;
    dst_local  = 3'd2;
    rtr.wait_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;

    r = '{pass: 1'b1, err: 16'd0, rx: 16'd0, lat: 16'd0};
    run(0, 1'b0, -1, 0, r, cyc);
    chk("count0_done_latency", 38'(cyc), 38'd1);

    r = '{pass: 1'b1, err: 16'd0, rx: 16'd4, lat: ECHO_LAT};
    run(4, 1'b1, -1, 0, r, cyc);

    r = '{pass: 1'b1, err: 16'd0, rx: 16'd1, lat: ECHO_LAT};
    run(1, 1'b1, -1, 10, r, cyc);

    r = '{pass: 1'b0, err: 16'd1, rx: 16'd4, lat: ECHO_LAT};
    run(4, 1'b1, 2, 0, r, cyc);

    r = '{pass: 1'b0, err: 16'd2, rx: 16'd0, lat: 16'd0};
    run(2, 1'b0, -1, 0, r, cyc);
    chk("timeout_run_length_30_40", 38'((cyc >= 30) && (cyc <= 40)), 38'd1);

    echo_on = 1'b0;
    count   = 16'd4;
    for (int i = 0; i < 4; i++) exp_pkt_q.push_back(tx_pkt(i));
    pulse_start();
    saw_wr = 1'b0;
    for (int i = 0; i < 50 && !saw_wr; i++) begin
      @(negedge clk);
      saw_wr = (rtr.wr_o === 1'b1);
    end
    chk("abort_run_wr_seen", 38'(saw_wr), 38'd1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk_all_zero("abort");
    exp_pkt_q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;

    r = '{pass: 1'b1, err: 16'd0, rx: 16'd2, lat: ECHO_LAT};
    run(2, 1'b1, -1, 0, r, cyc);

    chk("pkt_queue_drained", 38'(exp_pkt_q.size()), 38'd0);
    chk("res_queue_drained", 38'(exp_res_q.size()), 38'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test expected finish before 500000 ns");
    $fatal(1, "watchdog expired");
  end

endmodule
